led_seq_ctrl: RTL and testbench

//  Plays a programmable LED pattern table on the board LEDs. Each table entry

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_tick_gen.sv | 35 +++
 rtl/led_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and field layout for the LED pattern sequencer.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2
   } led_state_e;

   localparam int TICK_DIV_DEF = 50000;
   localparam int N_LED_DEF    = 4;
   localparam int DEPTH_DEF    = 8;
   localparam int DUR_W_DEF    = 8;

   // CFG_DATA layout: {mask, dur}; dur sits at the bottom
   localparam int DUR_LSB = 0;

   function automatic int mask_lsb(input int dur_w);
      return DUR_LSB + dur_w;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Clock prescaler producing a one-cycle tick every DIV enabled cycles.
module led_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && !clr_i && (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// Plays a programmable table of {LED mask, duration} entries on the LEDs,
// once or looping, with START/STOP control.
module led_seq_ctrl
   import led_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int N_LED    = N_LED_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int DUR_W    = DUR_W_DEF,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               CLK_50M,
   input  logic               RST,
   input  logic               CFG_WE,
   input  logic [AW-1:0]      CFG_ADDR,
   input  logic [N_LED+DUR_W-1:0] CFG_DATA,
   input  logic [AW-1:0]      LAST_IDX,
   input  logic               LOOP,
   input  logic               START,
   input  logic               STOP,
   output logic [N_LED-1:0]   LED,
   output logic               BUSY,
   output logic               DONE
);

   localparam int EW       = N_LED + DUR_W;
   localparam int MASK_LSB = mask_lsb(DUR_W);

   logic [EW-1:0] tbl_q [DEPTH];

   led_state_e        state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [AW-1:0]     last_q, last_d;
   logic              loop_q, loop_d;
   logic              fin_q, fin_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [N_LED-1:0]  led_q, led_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              tick, pre_clr, pre_en;
   logic [EW-1:0]     ent;
   logic [N_LED-1:0]  ent_mask;
   logic [DUR_W-1:0]  ent_dur;

   always_ff @(posedge CLK_50M) begin
      if (CFG_WE) begin
         tbl_q[CFG_ADDR] <= CFG_DATA;
      end
   end

   assign ent      = tbl_q[idx_q];
   assign ent_mask = ent[MASK_LSB +: N_LED];
   assign ent_dur  = ent[DUR_LSB +: DUR_W];

   led_tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick (
      .clk_i  (CLK_50M),
      .rst_i  (RST),
      .clr_i  (pre_clr),
      .en_i   (pre_en),
      .tick_o (tick)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      loop_d  = loop_q;
      fin_d   = fin_q;
      dur_d   = dur_q;
      led_d   = led_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pre_clr = 1'b0;
      pre_en  = 1'b0;
      if (STOP) begin
         state_d = ST_IDLE;
         led_d   = '0;
         busy_d  = 1'b0;
         fin_d   = 1'b0;
         pre_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (START) begin
                  state_d = ST_LOAD;
                  idx_d   = '0;
                  last_d  = LAST_IDX;
                  loop_d  = LOOP;
                  fin_d   = 1'b0;
                  busy_d  = 1'b1;
               end
            end
            ST_LOAD: begin
               pre_clr = 1'b1;
               // fin_q: last entry finished its time; close the pass here
               if (fin_q || (ent_dur == '0 && idx_q == last_q && !loop_q)) begin
                  state_d = ST_IDLE;
                  fin_d   = 1'b0;
                  led_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (ent_dur == '0) begin
                  idx_d = (idx_q != last_q) ? idx_q + 1'b1 : '0;
               end else begin
                  led_d   = ent_mask;
                  dur_d   = ent_dur;
                  state_d = ST_PLAY;
               end
            end
            ST_PLAY: begin
               pre_en = 1'b1;
               if (tick) begin
                  if (dur_q == DUR_W'(1)) begin
                     state_d = ST_LOAD;
                     if (idx_q != last_q) begin
                        idx_d = idx_q + 1'b1;
                     end else if (loop_q) begin
                        idx_d = '0;
                     end else begin
                        fin_d = 1'b1;
                     end
                  end else begin
                     dur_d = dur_q - 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         last_q  <= '0;
         loop_q  <= 1'b0;
         fin_q   <= 1'b0;
         dur_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         loop_q  <= loop_d;
         fin_q   <= fin_d;
         dur_q   <= dur_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign LED  = led_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4: table-driven traces
// of {inputs, expected LED/BUSY/DONE} plus a mid-stream reset sequence.
module tb_led_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [11:0] cfg_data = '0;
   logic [2:0]  last_idx = '0;
   logic        loop_en = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [3:0]  led;
   logic        busy;
   logic        done;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic        st;
      logic        sp;
      logic        we;
      logic [2:0]  addr;
      logic [11:0] data;
      logic [3:0]  led;
      logic        busy;
      logic        done;
      int          reps;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   led_seq_ctrl #(
      .TICK_DIV (4),
      .N_LED    (4),
      .DEPTH    (8),
      .DUR_W    (8)
   ) dut (
      .CLK_50M  (clk),
      .RST      (rst),
      .CFG_WE   (cfg_we),
      .CFG_ADDR (cfg_addr),
      .CFG_DATA (cfg_data),
      .LAST_IDX (last_idx),
      .LOOP     (loop_en),
      .START    (start),
      .STOP     (stop),
      .LED      (led),
      .BUSY     (busy),
      .DONE     (done)
   );

   task automatic chk(input string nm, input logic [5:0] exp);
      logic [5:0] got;
      got = {led, busy, done};
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got led=%h busy=%b done=%b, want led=%h busy=%b done=%b",
                  nm, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
      end
   endtask

   function automatic void add(input logic st, input logic sp, input logic we,
                               input logic [2:0] a, input logic [11:0] d,
                               input logic [3:0] l, input logic b,
                               input logic dn, input int n);
      vec_t v;
      v.st = st; v.sp = sp; v.we = we; v.addr = a; v.data = d;
      v.led = l; v.busy = b; v.done = dn; v.reps = n;
      vq.push_back(v);
   endfunction

   function automatic void ex(input logic [3:0] l, input logic b,
                              input logic dn, input int n);
      add(1'b0, 1'b0, 1'b0, 3'd0, 12'h0, l, b, dn, n);
   endfunction

   function automatic void wr(input logic [2:0] a, input logic [3:0] m,
                              input logic [7:0] d);
      add(1'b0, 1'b0, 1'b1, a, {m, d}, 4'h0, 1'b0, 1'b0, 1);
   endfunction

   // Called #1 after a rising edge; each rep drives then checks one cycle.
   task automatic run(input string nm);
      for (int i = 0; i < vq.size(); i++) begin
         for (int r = 0; r < vq[i].reps; r++) begin
            start    = (r == 0) ? vq[i].st : 1'b0;
            stop     = (r == 0) ? vq[i].sp : 1'b0;
            cfg_we   = (r == 0) ? vq[i].we : 1'b0;
            cfg_addr = vq[i].addr;
            cfg_data = vq[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("%s row%0d rep%0d", nm, i, r),
                {vq[i].led, vq[i].busy, vq[i].done});
         end
      end
      start  = 1'b0;
      stop   = 1'b0;
      cfg_we = 1'b0;
      vq.delete();
   endtask

   initial begin
      #1;
      chk("reset_state", 6'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("after_reset", 6'b0);

      // One-shot pass: 1 for 9 cycles, 3 for 5, then DONE
      last_idx = 3'd1;
      loop_en  = 1'b0;
      wr(3'd0, 4'h1, 8'd2);
      wr(3'd1, 4'h3, 8'd1);
      add(1'b1, 1'b0, 1'b0, 3'd0, 12'h0, 4'h0, 1'b1, 1'b0, 1);
      ex(4'h1, 1'b1, 1'b0, 9);
      ex(4'h3, 1'b1, 1'b0, 5);
      ex(4'h0, 1'b0, 1'b1, 1);
      ex(4'h0, 1'b0, 1'b0, 3);
      run("oneshot");

      // Looping pass, STOP while entry 0 is showing
      loop_en = 1'b1;
      add(1'b1, 1'b0, 1'b0, 3'd0, 12'h0, 4'h0, 1'b1, 1'b0, 1);
      for (int k = 0; k < 3; k++) begin
         ex(4'h1, 1'b1, 1'b0, 9);
         ex(4'h3, 1'b1, 1'b0, 5);
      end
      ex(4'h1, 1'b1, 1'b0, 3);
      add(1'b0, 1'b1, 1'b0, 3'd0, 12'h0, 4'h0, 1'b0, 1'b0, 1);
      ex(4'h0, 1'b0, 1'b0, 3);
      run("loop_stop");

      // Zero-duration entry is skipped in a single cycle
      last_idx = 3'd2;
      loop_en  = 1'b0;
      wr(3'd0, 4'hF, 8'd1);
      wr(3'd1, 4'h5, 8'd0);
      wr(3'd2, 4'hA, 8'd1);
      add(1'b1, 1'b0, 1'b0, 3'd0, 12'h0, 4'h0, 1'b1, 1'b0, 1);
      ex(4'hF, 1'b1, 1'b0, 6);
      ex(4'hA, 1'b1, 1'b0, 5);
      ex(4'h0, 1'b0, 1'b1, 1);
      ex(4'h0, 1'b0, 1'b0, 2);
      run("skip");

      // START+STOP together while idle; START while busy has no effect
      last_idx = 3'd1;
      wr(3'd0, 4'h1, 8'd2);
      wr(3'd1, 4'h3, 8'd1);
      add(1'b1, 1'b1, 1'b0, 3'd0, 12'h0, 4'h0, 1'b0, 1'b0, 1);
      ex(4'h0, 1'b0, 1'b0, 2);
      add(1'b1, 1'b0, 1'b0, 3'd0, 12'h0, 4'h0, 1'b1, 1'b0, 1);
      ex(4'h1, 1'b1, 1'b0, 4);
      add(1'b1, 1'b0, 1'b0, 3'd0, 12'h0, 4'h1, 1'b1, 1'b0, 5);
      ex(4'h3, 1'b1, 1'b0, 5);
      ex(4'h0, 1'b0, 1'b1, 1);
      ex(4'h0, 1'b0, 1'b0, 2);
      run("start_stop");

      // Rewrite entry 0 while it plays: new mask shows from the next pass
      loop_en = 1'b1;
      add(1'b1, 1'b0, 1'b0, 3'd0, 12'h0, 4'h0, 1'b1, 1'b0, 1);
      ex(4'h1, 1'b1, 1'b0, 4);
      add(1'b0, 1'b0, 1'b1, 3'd0, {4'h8, 8'd1}, 4'h1, 1'b1, 1'b0, 5);
      ex(4'h3, 1'b1, 1'b0, 5);
      ex(4'h8, 1'b1, 1'b0, 5);
      ex(4'h3, 1'b1, 1'b0, 5);
      ex(4'h8, 1'b1, 1'b0, 2);
      add(1'b0, 1'b1, 1'b0, 3'd0, 12'h0, 4'h0, 1'b0, 1'b0, 1);
      ex(4'h0, 1'b0, 1'b0, 2);
      run("rewrite");

      // Asynchronous reset mid-stream with random inputs
      wr(3'd0, 4'h1, 8'd2);
      add(1'b1, 1'b0, 1'b0, 3'd0, 12'h0, 4'h0, 1'b1, 1'b0, 1);
      ex(4'h1, 1'b1, 1'b0, 9);
      ex(4'h3, 1'b1, 1'b0, 3);
      run("pre_rst");
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", 6'b0);
      for (int k = 0; k < 4; k++) begin
         start    = 1'($urandom);
         stop     = 1'($urandom);
         cfg_we   = 1'($urandom);
         cfg_addr = 3'($urandom);
         cfg_data = 12'($urandom);
         last_idx = 3'($urandom);
         loop_en  = 1'($urandom);
         @(posedge clk);
         #1;
         chk($sformatf("rst_hold%0d", k), 6'b0);
      end
      start  = 1'b0;
      stop   = 1'b0;
      cfg_we = 1'b0;
      rst    = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_rst%0d", k), 6'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
